// File: rtl/uart_rpm_cmd_decoder_pkg.sv
// Shared command bytes, decoder state encoding and record-size helper
// for the UART target-RPM command decoder.
package uart_rpm_cmd_decoder_pkg;

    localparam logic [7:0] CMD_SET_DEF   = 8'h91;
    localparam logic [7:0] CMD_RET_DEF   = 8'hFF;
    localparam logic [7:0] CMD_ESTOP_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CHN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    // Number of whole bytes needed to carry a setpoint of dw bits.
    function automatic int calc_nb(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_rpm_cmd_decoder_timer.sv
// Inter-byte timeout counter: counts enabled idle cycles since the last
// clear and pulses o_expire on the TIMEOUT_CYC-th one.
module uart_frame_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    // A clear on the expiry cycle suppresses the pulse, so an arriving byte wins.
    assign o_expire = i_enable && !i_clear && (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rpm_cmd_decoder.sv
// Decodes host UART command records into per-channel signed target-RPM
// updates, stop flags and a saturating rejected-record counter.
module uart_rpm_cmd_decoder
    import uart_rpm_cmd_decoder_pkg::*;
#(
    parameter int         DATA_WIDTH  = 16,
    parameter int         NUM_CHN     = 4,
    parameter int         CHN_WIDTH   = 3,
    parameter int         MIN_RPM     = 4,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] CMD_SET     = CMD_SET_DEF,
    parameter logic [7:0] CMD_RET     = CMD_RET_DEF,
    parameter logic [7:0] CMD_ESTOP   = CMD_ESTOP_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  tr_valid_o,
    output logic [CHN_WIDTH-1:0]  tr_chn_o,
    output logic [DATA_WIDTH-1:0] tr_data_o,
    output logic [NUM_CHN-1:0]    stop_o,
    output logic                  brake_o,
    output logic [7:0]            err_cnt_o,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o
);

    localparam int NB  = calc_nb(DATA_WIDTH);
    localparam int DW8 = NB * 8;
    localparam logic signed [DATA_WIDTH-1:0] MIN_POS = DATA_WIDTH'(MIN_RPM);
    localparam logic signed [DATA_WIDTH-1:0] MIN_NEG = DATA_WIDTH'(-MIN_RPM);

    state_t         r_state, w_next;
    logic [7:0]     r_chn;
    logic [7:0]     r_csum;
    logic [DW8-1:0] r_data;
    logic [3:0]     r_bcnt;

    logic w_expire, w_timer_en;
    logic w_load_chn, w_shift, w_check, w_estop, w_abort;
    logic w_accept, w_reject;
    logic signed [DATA_WIDTH-1:0] w_setp;
    logic w_dead;

    assign w_timer_en = (r_state == ST_DATA) || (r_state == ST_CSUM);

    uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .i_clear  (rx_valid_i),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load_chn = 1'b0;
        w_shift    = 1'b0;
        w_check    = 1'b0;
        w_estop    = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            ST_IDLE: if (rx_valid_i) begin
                if (rx_data_i == CMD_SET)        w_next = ST_CHN;
                else if (rx_data_i == CMD_ESTOP) w_estop = 1'b1;
            end
            ST_CHN: if (rx_valid_i) begin
                if (rx_data_i == CMD_RET) begin
                    w_next = ST_IDLE;
                end else if (rx_data_i == CMD_ESTOP) begin
                    w_estop = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_load_chn = 1'b1;
                    w_next     = ST_DATA;
                end
            end
            ST_DATA: if (rx_valid_i) begin
                w_shift = 1'b1;
                if (r_bcnt == 4'(NB - 1)) w_next = ST_CSUM;
            end else if (w_expire) begin
                w_abort = 1'b1;
                w_next  = ST_CHN;
            end
            ST_CSUM: if (rx_valid_i) begin
                w_check = 1'b1;
                w_next  = ST_CHN;
            end else if (w_expire) begin
                w_abort = 1'b1;
                w_next  = ST_CHN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_setp   = r_data[DATA_WIDTH-1:0];
    // Strict signed bounds keep the most negative value out of the dead zone.
    assign w_dead   = (w_setp < MIN_POS) && (w_setp > MIN_NEG);
    assign w_accept = w_check && (rx_data_i == r_csum) && (r_chn < 8'(NUM_CHN));
    assign w_reject = (w_check && !w_accept) || w_abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_chn      <= '0;
            r_csum     <= '0;
            r_data     <= '0;
            r_bcnt     <= '0;
            tr_valid_o <= 1'b0;
            tr_chn_o   <= '0;
            tr_data_o  <= '0;
            stop_o     <= '1;
            err_cnt_o  <= '0;
        end else begin
            tr_valid_o <= w_accept;
            tr_chn_o   <= w_accept ? r_chn[CHN_WIDTH-1:0] : '0;
            tr_data_o  <= w_accept ? w_setp : '0;
            if (w_load_chn) begin
                r_chn  <= rx_data_i;
                r_csum <= rx_data_i;
                r_bcnt <= '0;
            end
            if (w_shift) begin
                r_data <= (r_data << 8) | DW8'(rx_data_i);
                r_csum <= r_csum ^ rx_data_i;
                r_bcnt <= r_bcnt + 1'b1;
            end
            if (w_estop) begin
                stop_o <= '1;
            end else if (w_accept) begin
                for (int i = 0; i < NUM_CHN; i++) begin
                    if (r_chn == 8'(i)) stop_o[i] <= w_dead;
                end
            end
            if (w_reject && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    assign brake_o     = &stop_o;
    assign busy_o      = (r_state != ST_IDLE);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_rpm_cmd_decoder.sv
// Bench for uart_rpm_cmd_decoder: directed command sequences plus randomized
// byte streams checked every cycle against a record-level reference model.
module tb_uart_rpm_cmd_decoder;

    localparam int TO      = 64;
    localparam int NB      = 2;
    localparam int NUM_CHN = 4;
    localparam int MIN_RPM = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tr_valid_o;
    logic [2:0]  tr_chn_o;
    logic [15:0] tr_data_o;
    logic [3:0]  stop_o;
    logic        brake_o;
    logic [7:0]  err_cnt_o;
    logic        busy_o;
    logic [1:0]  dbg_state_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rpm_cmd_decoder #(
        .DATA_WIDTH(16), .NUM_CHN(NUM_CHN), .CHN_WIDTH(3),
        .MIN_RPM(MIN_RPM), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tr_valid_o(tr_valid_o), .tr_chn_o(tr_chn_o), .tr_data_o(tr_data_o),
        .stop_o(stop_o), .brake_o(brake_o), .err_cnt_o(err_cnt_o),
        .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    // Reference model: a set-mode flag plus the bytes of the record in flight.
    bit          m_set = 0;
    logic [7:0]  rec_q[$];
    int          gap = 0;
    logic [3:0]  m_stop = 4'hF;
    int          m_err = 0;
    logic        m_valid = 0;
    logic [2:0]  m_chn = 0;
    logic [15:0] m_data = 0;

    task automatic model_reset();
        m_set = 0; rec_q.delete(); gap = 0; m_stop = 4'hF; m_err = 0;
        m_valid = 0; m_chn = 0; m_data = 0;
    endtask

    task automatic err_inc();
        if (m_err < 255) m_err++;
    endtask

    task automatic finish_record();
        logic [7:0] x;
        int val, sv, mag;
        x = 8'h00;
        for (int i = 0; i < NB + 1; i++) x = x ^ rec_q[i];
        val = 0;
        for (int i = 1; i <= NB; i++) val = (val << 8) | int'(rec_q[i]);
        sv = val & 32'hFFFF;
        if (sv >= 32768) sv = sv - 65536;
        mag = (sv < 0) ? -sv : sv;
        if (rec_q[NB+1] == x && int'(rec_q[0]) < NUM_CHN) begin
            m_valid = 1;
            m_chn   = rec_q[0][2:0];
            m_data  = val[15:0];
            m_stop[rec_q[0][1:0]] = (mag < MIN_RPM);
        end else begin
            err_inc();
        end
        rec_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        m_valid = 0; m_chn = 0; m_data = 0;
        if (v) begin
            gap = 0;
            if (!m_set) begin
                if (b == 8'h91)      m_set = 1;
                else if (b == 8'hA5) m_stop = 4'hF;
            end else if (rec_q.size() == 0) begin
                if (b == 8'hFF)      m_set = 0;
                else if (b == 8'hA5) begin m_stop = 4'hF; m_set = 0; end
                else                 rec_q.push_back(b);
            end else begin
                rec_q.push_back(b);
                if (rec_q.size() == NB + 2) finish_record();
            end
        end else if (rec_q.size() > 0) begin
            gap++;
            if (gap == TO) begin
                err_inc();
                rec_q.delete();
                gap = 0;
            end
        end
    endtask

    function automatic logic [1:0] m_state();
        if (!m_set)                 return 2'd0;
        else if (rec_q.size() == 0) return 2'd1;
        else if (rec_q.size() <= NB) return 2'd2;
        else                         return 2'd3;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_reset();
        else       model_step(rx_valid, rx_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("tr_valid", 32'(tr_valid_o), 32'(m_valid));
        chk("tr_chn",   32'(tr_chn_o),   32'(m_chn));
        chk("tr_data",  32'(tr_data_o),  32'(m_data));
        chk("stop",     32'(stop_o),     32'(m_stop));
        chk("brake",    32'(brake_o),    32'(&m_stop));
        chk("err_cnt",  32'(err_cnt_o),  32'(m_err));
        chk("busy",     32'(busy_o),     32'(m_set));
        chk("state",    32'(dbg_state_o), 32'(m_state()));
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_rand_record();
        logic [7:0]  c, cs;
        logic [15:0] d;
        int sv;
        c = 8'($urandom_range(0, 5));
        if ($urandom_range(0, 1) == 1) begin
            sv = int'($urandom_range(0, 12)) - 6;
            d  = sv[15:0];
        end else begin
            d = 16'($urandom);
        end
        cs = c ^ d[15:8] ^ d[7:0];
        if ($urandom_range(0, 99) < 15) cs = cs ^ 8'($urandom_range(1, 255));
        send(c);
        idle($urandom_range(0, 2));
        send(d[15:8]);
        if ($urandom_range(0, 19) == 0) idle(($urandom_range(0, 1) == 1) ? TO : TO - 1);
        else idle($urandom_range(0, 2));
        send(d[7:0]);
        idle($urandom_range(0, 2));
        send(cs);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("rst_stop",  32'(stop_o), 32'hF);
        chk("rst_brake", 32'(brake_o), 32'h1);
        chk("rst_err",   32'(err_cnt_o), 32'h0);
        chk("rst_busy",  32'(busy_o), 32'h0);

        send(8'h91); send(8'h01); send(8'h01); send(8'h2C); send(8'h2C);
        chk("set1_valid", 32'(tr_valid_o), 32'h1);
        chk("set1_chn",   32'(tr_chn_o), 32'h1);
        chk("set1_data",  32'(tr_data_o), 32'h012C);
        chk("set1_model", 32'(m_data), 32'h012C);
        chk("set1_stop",  32'(stop_o), 32'hD);
        chk("set1_brake", 32'(brake_o), 32'h0);

        send(8'h02); send(8'hFF); send(8'hFE); send(8'h03);
        chk("neg_valid", 32'(tr_valid_o), 32'h1);
        chk("neg_chn",   32'(tr_chn_o), 32'h2);
        chk("neg_data",  32'(tr_data_o), 32'hFFFE);
        chk("neg_stop",  32'(stop_o), 32'hD);

        send(8'h01); send(8'h01); send(8'h2C); send(8'h2D);
        chk("badcs_valid", 32'(tr_valid_o), 32'h0);
        chk("badcs_err",   32'(err_cnt_o), 32'h1);
        send(8'h05); send(8'h00); send(8'h10); send(8'h15);
        chk("badch_valid", 32'(tr_valid_o), 32'h0);
        chk("badch_err",   32'(err_cnt_o), 32'h2);
        chk("badch_state", 32'(dbg_state_o), 32'h1);

        send(8'h01); send(8'h01); idle(TO);
        chk("to_err",   32'(err_cnt_o), 32'h3);
        chk("to_state", 32'(dbg_state_o), 32'h1);
        send(8'h01); send(8'h01); send(8'h2C); send(8'h2C);
        chk("after_to_valid", 32'(tr_valid_o), 32'h1);
        send(8'h01); send(8'h01); idle(TO - 1); send(8'h2C); send(8'h2C);
        chk("edge_valid", 32'(tr_valid_o), 32'h1);
        chk("edge_err",   32'(err_cnt_o), 32'h3);

        send(8'hFF);
        chk("ret_busy", 32'(busy_o), 32'h0);
        send(8'h91); send(8'h00); send(8'h00); send(8'h64); send(8'h64);
        chk("run0_stop", 32'(stop_o), 32'hC);
        send(8'hA5);
        chk("estop_stop",  32'(stop_o), 32'hF);
        chk("estop_brake", 32'(brake_o), 32'h1);
        chk("estop_busy",  32'(busy_o), 32'h0);
        chk("estop_valid", 32'(tr_valid_o), 32'h0);

        send(8'h91); send(8'h01); send(8'h01);
        pulse_reset();
        chk("rstmid_state", 32'(dbg_state_o), 32'h0);
        chk("rstmid_err",   32'(err_cnt_o), 32'h0);
        send(8'h2C);
        chk("rstmid_valid", 32'(tr_valid_o), 32'h0);

        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                if (!m_set && $urandom_range(0, 4) != 0) send(8'h91);
                send_rand_record();
            end else if (r < 68) send(8'h91);
            else if (r < 76) send(8'($urandom));
            else if (r < 80) send(8'hA5);
            else if (r < 85) send(8'hFF);
            else if (r < 99) idle($urandom_range(0, 5));
            else pulse_reset();
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
